// File: rtl/clkgen_pkg.sv
// Shared constants and helpers for the clkgen_param divider family.
package clkgen_pkg;

   localparam int CLKGEN_MAX_STAGES = 8;
   localparam int CLKGEN_DEF_PRE_W  = 4;

   // Period of clk_div[stage] in clk8f cycles for a given prescale value.
   function automatic int unsigned clkgen_period(input int unsigned stage,
                                                 input int unsigned prescale);
      return (32'd1 << (stage + 32'd1)) * (prescale + 32'd1);
   endfunction

endpackage

// File: rtl/clkgen_prescaler.sv
// Prescaler for clkgen_param: counts 0..pre_lat and emits a one-cycle tick.
// pre_lat only reloads at reset, resync or a tick, so prescale edits never cut an interval short.
module clkgen_prescaler
   import clkgen_pkg::*;
#(
   parameter int PRE_W = CLKGEN_DEF_PRE_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             resync_i,
   input  logic [PRE_W-1:0] prescale_i,
   output logic             tick_o
);

   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [PRE_W-1:0] pre_lat_q, pre_lat_d;
   logic             at_end_s;

   // Next-state for the prescale counter and latched period.
   always_comb begin
      pre_cnt_d = pre_cnt_q;
      pre_lat_d = pre_lat_q;
      at_end_s  = (pre_cnt_q == pre_lat_q);
      if (resync_i) begin
         pre_cnt_d = '0;
         pre_lat_d = prescale_i;
      end else if (en_i && at_end_s) begin
         pre_cnt_d = '0;
         pre_lat_d = prescale_i;
      end else if (en_i) begin
         pre_cnt_d = pre_cnt_q + PRE_W'(1);
      end else begin
         pre_cnt_d = pre_cnt_q;
      end
   end

   // resync outranks en, so a tick is never issued while realigning.
   assign tick_o = en_i & ~resync_i & at_end_s;

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pre_cnt_q <= '0;
         pre_lat_q <= prescale_i;
      end else begin
         pre_cnt_q <= pre_cnt_d;
         pre_lat_q <= pre_lat_d;
      end
   end

endmodule

// File: rtl/clkgen_param.sv
// Single-clock binary divider with per-stage strobes and a sticky lock flag.
// Optional CLKGEN_STROBE_EN: when undefined, rise_stb/fall_stb are tied to 0.
module clkgen_param
   import clkgen_pkg::*;
#(
   parameter int STAGES = 3,
   parameter int PRE_W  = CLKGEN_DEF_PRE_W
) (
   input  logic              clk8f,
   input  logic              reset,
   input  logic              en,
   input  logic              resync,
   input  logic [PRE_W-1:0]  prescale,
   output logic [STAGES-1:0] clk_div,
   output logic [STAGES-1:0] rise_stb,
   output logic [STAGES-1:0] fall_stb,
   output logic              locked
);

   logic              tick_s;
   logic [STAGES-1:0] div_q, div_d, div_inc_s;
   logic              locked_q, locked_d;

   clkgen_prescaler #(
      .PRE_W(PRE_W)
   ) u_pre (
      .clk_i     (clk8f),
      .rst_ni    (reset),
      .en_i      (en),
      .resync_i  (resync),
      .prescale_i(prescale),
      .tick_o    (tick_s)
   );

   assign div_inc_s = div_q + STAGES'(1);

   // Divider count and lock; lock sets on the first all-ones wrap.
   always_comb begin
      div_d    = div_q;
      locked_d = locked_q;
      if (resync) begin
         div_d    = '0;
         locked_d = 1'b0;
      end else if (tick_s) begin
         div_d    = div_inc_s;
         locked_d = locked_q | (&div_q);
      end else begin
         div_d    = div_q;
         locked_d = locked_q;
      end
   end

   // Divider and lock registers.
   always_ff @(posedge clk8f) begin
      if (!reset) begin
         div_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         div_q    <= div_d;
         locked_q <= locked_d;
      end
   end

   assign clk_div = div_q;
   assign locked  = locked_q;

`ifdef CLKGEN_STROBE_EN
   logic [STAGES-1:0] rise_q, rise_d, fall_q, fall_d;

   // Edge strobes are registered on the tick edge, so they align with clk_div.
   always_comb begin
      rise_d = '0;
      fall_d = '0;
      if (resync) begin
         rise_d = '0;
         fall_d = '0;
      end else if (tick_s) begin
         rise_d = ~div_q & div_inc_s;
         fall_d = div_q & ~div_inc_s;
      end else begin
         rise_d = '0;
         fall_d = '0;
      end
   end

   // Strobe registers.
   always_ff @(posedge clk8f) begin
      if (!reset) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise_stb = rise_q;
   assign fall_stb = fall_q;
`else
   assign rise_stb = '0;
   assign fall_stb = '0;
`endif

endmodule
